// File: rtl/trap_pkg.sv
// Shared definitions for the machine-mode trap sequencer: FSM encoding,
// cause codes, mip bit positions, CSR addresses and the trap-target helper.
package trap_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FLUSH = 2'd1,
    ST_ENTER = 2'd2,
    ST_RET   = 2'd3
  } trap_state_e;

  typedef enum logic {
    KIND_TRAP = 1'b0,
    KIND_MRET = 1'b1
  } trap_kind_e;

  // Interrupt codes (low bits of mcause with bit 31 set)
  localparam logic [3:0] IRQ_CODE_MSI = 4'd3;
  localparam logic [3:0] IRQ_CODE_MTI = 4'd7;
  localparam logic [3:0] IRQ_CODE_MEI = 4'd11;

  localparam logic [31:0] CAUSE_ILLEGAL = 32'd2;
  localparam logic [31:0] CAUSE_EBREAK  = 32'd3;
  localparam logic [31:0] CAUSE_ECALL   = 32'd11;

  localparam int MIP_MSIP_BIT = 3;
  localparam int MIP_MTIP_BIT = 7;
  localparam int MIP_MEIP_BIT = 11;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MIE     = 12'h304;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MIP     = 12'h344;

  // Handler address: vectored mode only offsets interrupts, exceptions use the base.
  function automatic logic [31:0] trap_target(input logic [31:0] mtvec,
                                              input logic        is_irq,
                                              input logic [3:0]  code);
    logic [31:0] base;
    base = {mtvec[31:2], 2'b00};
    if (is_irq && (mtvec[1:0] == 2'b01)) begin
      base = base + {26'b0, code, 2'b00};
    end
    return base;
  endfunction

endpackage

// File: rtl/trap_ctrl_if.sv
// Boundary/CSR-side signal bundle of the trap sequencer.
// Handshake: instr_valid_in is a one-sided valid; the sequencer only
// samples it in IDLE (state_dbg == ST_IDLE acts as the implicit ready).
interface trap_ctrl_if;
  import trap_pkg::*;

  logic        instr_valid_in;
  logic [31:0] pc_in;
  logic        illegal_in;
  logic        ecall_in;
  logic        ebreak_in;
  logic        mret_in;
  logic        mie_in;
  logic        meie_in;
  logic        mtie_in;
  logic        msie_in;
  logic        e_irq_in;
  logic        t_irq_in;
  logic        s_irq_in;
  logic [31:0] mtvec_in;
  logic [31:0] mepc_in;

  logic        flush_out;
  logic        mie_clear_out;
  logic        mie_set_out;
  logic        mepc_wr_out;
  logic [31:0] mepc_out;
  logic        mcause_wr_out;
  logic [31:0] mcause_out;
  logic        redirect_out;
  logic [31:0] redirect_pc_out;
  logic [31:0] mip_out;
  trap_state_e state_dbg;

  modport master (
    output instr_valid_in, pc_in, illegal_in, ecall_in, ebreak_in, mret_in,
           mie_in, meie_in, mtie_in, msie_in, e_irq_in, t_irq_in, s_irq_in,
           mtvec_in, mepc_in,
    input  flush_out, mie_clear_out, mie_set_out, mepc_wr_out, mepc_out,
           mcause_wr_out, mcause_out, redirect_out, redirect_pc_out, mip_out,
           state_dbg
  );

  modport slave (
    input  instr_valid_in, pc_in, illegal_in, ecall_in, ebreak_in, mret_in,
           mie_in, meie_in, mtie_in, msie_in, e_irq_in, t_irq_in, s_irq_in,
           mtvec_in, mepc_in,
    output flush_out, mie_clear_out, mie_set_out, mepc_wr_out, mepc_out,
           mcause_wr_out, mcause_out, redirect_out, redirect_pc_out, mip_out,
           state_dbg
  );

endinterface

// File: rtl/irq_prio_enc.sv
// Synchronises the interrupt levels, builds mip, and picks the highest
// priority enabled interrupt (MEI > MSI > MTI).
module irq_prio_enc
  import trap_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        e_irq_in,
  input  logic        t_irq_in,
  input  logic        s_irq_in,
  input  logic        mie_in,
  input  logic        meie_in,
  input  logic        mtie_in,
  input  logic        msie_in,
  output logic [31:0] mip_out,
  output logic        irq_pend_out,
  output logic [3:0]  irq_code_out
);

  logic [SYNC_STAGES-1:0] e_sync;
  logic [SYNC_STAGES-1:0] t_sync;
  logic [SYNC_STAGES-1:0] s_sync;
  logic meip, mtip, msip;
  logic mei_en, mti_en, msi_en;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      e_sync <= '0;
      t_sync <= '0;
      s_sync <= '0;
    end else begin
      e_sync <= {e_sync[SYNC_STAGES-2:0], e_irq_in};
      t_sync <= {t_sync[SYNC_STAGES-2:0], t_irq_in};
      s_sync <= {s_sync[SYNC_STAGES-2:0], s_irq_in};
    end
  end

  assign meip = e_sync[SYNC_STAGES-1];
  assign mtip = t_sync[SYNC_STAGES-1];
  assign msip = s_sync[SYNC_STAGES-1];

  assign mip_out = {20'b0, meip, 3'b0, mtip, 3'b0, msip, 3'b0};

  assign mei_en = mie_in & meip & meie_in;
  assign msi_en = mie_in & msip & msie_in;
  assign mti_en = mie_in & mtip & mtie_in;

  always_comb begin
    irq_pend_out = 1'b1;
    irq_code_out = IRQ_CODE_MEI;
    if (mei_en) begin
      irq_code_out = IRQ_CODE_MEI;
    end else if (msi_en) begin
      irq_code_out = IRQ_CODE_MSI;
    end else if (mti_en) begin
      irq_code_out = IRQ_CODE_MTI;
    end else begin
      irq_pend_out = 1'b0;
      irq_code_out = 4'd0;
    end
  end

endmodule

// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer: evaluates traps/MRET at instruction
// boundaries, drains the pipeline, then enters the handler or returns.
module trap_ctrl
  import trap_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int SYNC_STAGES  = 2
) (
  input  logic         clk_in,
  input  logic         rst_in,
  trap_ctrl_if.slave   bus
);

  localparam int CW = (FLUSH_CYCLES < 2) ? 1 : $clog2(FLUSH_CYCLES);

  trap_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  trap_kind_e  kind_q;
  logic [31:0] cause_q;
  logic [31:0] pc_q;
  logic        is_irq_q;
  logic [3:0]  code_q;

  logic        irq_pend;
  logic [3:0]  irq_code;
  logic        take_trap;
  logic        take_mret;
  logic [31:0] cause_sel;

  irq_prio_enc #(.SYNC_STAGES(SYNC_STAGES)) u_prio (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .e_irq_in     (bus.e_irq_in),
    .t_irq_in     (bus.t_irq_in),
    .s_irq_in     (bus.s_irq_in),
    .mie_in       (bus.mie_in),
    .meie_in      (bus.meie_in),
    .mtie_in      (bus.mtie_in),
    .msie_in      (bus.msie_in),
    .mip_out      (bus.mip_out),
    .irq_pend_out (irq_pend),
    .irq_code_out (irq_code)
  );

  assign take_trap = (state_q == ST_IDLE) & bus.instr_valid_in &
                     (irq_pend | bus.illegal_in | bus.ecall_in | bus.ebreak_in);
  assign take_mret = (state_q == ST_IDLE) & bus.instr_valid_in & ~take_trap & bus.mret_in;

  // Fixed priority: interrupt > illegal > ecall > ebreak.
  always_comb begin
    cause_sel = CAUSE_EBREAK;
    if (irq_pend) begin
      cause_sel = {1'b1, 27'b0, irq_code};
    end else if (bus.illegal_in) begin
      cause_sel = CAUSE_ILLEGAL;
    end else if (bus.ecall_in) begin
      cause_sel = CAUSE_ECALL;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Everything about the trap is committed at detection; FLUSH ignores inputs.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      kind_q   <= KIND_TRAP;
      cause_q  <= '0;
      pc_q     <= '0;
      is_irq_q <= 1'b0;
      code_q   <= '0;
    end else if (take_trap) begin
      kind_q   <= KIND_TRAP;
      cause_q  <= cause_sel;
      pc_q     <= {bus.pc_in[31:2], 2'b00};
      is_irq_q <= irq_pend;
      code_q   <= irq_code;
    end else if (take_mret) begin
      kind_q   <= KIND_MRET;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (take_trap || take_mret) begin
          state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (cnt_q == CW'(FLUSH_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = (kind_q == KIND_MRET) ? ST_RET : ST_ENTER;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_ENTER: state_d = ST_IDLE;
      ST_RET:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Strobes decode straight from state so an async reset kills them at once.
  always_comb begin
    bus.flush_out       = (state_q == ST_FLUSH);
    bus.mie_clear_out   = (state_q == ST_ENTER);
    bus.mepc_wr_out     = (state_q == ST_ENTER);
    bus.mcause_wr_out   = (state_q == ST_ENTER);
    bus.mie_set_out     = (state_q == ST_RET);
    bus.redirect_out    = (state_q == ST_ENTER) || (state_q == ST_RET);
    bus.redirect_pc_out = '0;
    if (state_q == ST_ENTER) begin
      bus.redirect_pc_out = trap_target(bus.mtvec_in, is_irq_q, code_q);
    end else if (state_q == ST_RET) begin
      bus.redirect_pc_out = bus.mepc_in;
    end
  end

  assign bus.mepc_out   = pc_q;
  assign bus.mcause_out = cause_q;
  assign bus.state_dbg  = state_q;

endmodule
